// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the fetch stage and its prefetch FIFO.
// fetch_entry_t mirrors the {pc, insn} layout the FIFO stores at the default widths.
package cpu_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned INSN_BYTES = 4;
  localparam logic [WORD_W-1:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction ROM port, redirect input and decode handshake.
// master is the fetch stage, slave is its surroundings (ROM, execute, decode).
interface if_stage_if #(
  parameter int unsigned address_size = 32,
  parameter int unsigned word_size    = 32
);

  logic [address_size-1:0] imem_addr;
  logic [word_size-1:0]    imem_insn;
  logic                    redirect_valid;
  logic [address_size-1:0] redirect_pc;
  logic                    id_valid;
  logic                    id_ready;
  logic [address_size-1:0] id_pc;
  logic [word_size-1:0]    id_insn;

  modport master (
    output imem_addr, id_valid, id_pc, id_insn,
    input  imem_insn, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, id_valid, id_pc, id_insn,
    output imem_insn, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with a single-cycle flush; head data reads as zero when empty.
// depth must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned width = ADDR_W + WORD_W,
  parameter int unsigned depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [width-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [width-1:0] head_data
);

  localparam int unsigned ptr_w = $clog2(depth);
  localparam int unsigned cnt_w = ptr_w + 1;

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [cnt_w-1:0] count;

  assign full      = (count == cnt_w'(depth));
  assign empty     = (count == '0);
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_w'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_w'(1);
      end
      count <= count + cnt_w'(push) - cnt_w'(pop);
    end
  end

  // When full, wr_ptr == rd_ptr: a same-cycle push overwrites the slot being popped.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, captures ROM data into the prefetch FIFO and
// presents {pc, insn} to decode; a redirect flushes all prefetched entries.
module if_stage
  import cpu_pkg::*;
#(
  parameter int unsigned           address_size = 32,
  parameter int unsigned           word_size    = 32,
  parameter logic [address_size-1:0] reset_pc  = '0,
  parameter int unsigned           fifo_depth   = 2
) (
  input logic      clk,
  input logic      rst,
  if_stage_if.master bus
);

  logic [address_size-1:0] pc;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [address_size+word_size-1:0] head;

  assign bus.imem_addr = pc;
  assign bus.id_valid  = !empty;
  assign bus.id_pc     = head[address_size+word_size-1:word_size];
  assign bus.id_insn   = head[word_size-1:0];

  assign pop  = bus.id_valid & bus.id_ready;
  assign push = !bus.redirect_valid & (!full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= reset_pc;
    end else if (bus.redirect_valid) begin
      pc <= {bus.redirect_pc[address_size-1:2], 2'b00};
    end else if (push) begin
      pc <= pc + address_size'(INSN_BYTES);
    end
  end

  fetch_fifo #(
    .width (address_size + word_size),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .push_data ({pc, bus.imem_insn}),
    .full      (full),
    .empty     (empty),
    .head_data (head)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: reset, streaming, backpressure,
// redirects (full FIFO and simultaneous pop), PC wrap-around and mid-run reset.
module tb_if_stage;

  logic clk = 1'b0;
  logic rst;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  if_stage_if #(.address_size(32), .word_size(32)) bus ();
  if_stage_if #(.address_size(32), .word_size(32)) bus_w ();

  // ROM: word i holds 32'h1000_0000 + i
  assign bus.imem_insn   = 32'h1000_0000 + (bus.imem_addr >> 2);
  assign bus_w.imem_insn = 32'h1000_0000 + (bus_w.imem_addr >> 2);

  if_stage #(
    .address_size (32),
    .word_size    (32),
    .reset_pc     (32'h0000_0000),
    .fifo_depth   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  if_stage #(
    .address_size (32),
    .word_size    (32),
    .reset_pc     (32'hFFFF_FFF8),
    .fifo_depth   (2)
  ) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_w.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst                = 1'b1;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus_w.id_ready       = 1'b1;
    bus_w.redirect_valid = 1'b0;
    bus_w.redirect_pc    = '0;

    // reset release
    step();
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", {31'b0, bus.id_valid}, 32'h0);
    check("rst_pc_zero", bus.id_pc, 32'h0);
    check("rst_insn_zero", bus.id_insn, 32'h0);
    check("wrap_rst_addr", bus_w.imem_addr, 32'hFFFF_FFF8);
    step();
    check("rst_addr2", bus.imem_addr, 32'h0);
    check("rst_valid2", {31'b0, bus.id_valid}, 32'h0);
    rst = 1'b0;
    step();
    check("first_valid", {31'b0, bus.id_valid}, 32'h1);
    check("first_pc", bus.id_pc, 32'h0);
    check("first_insn", bus.id_insn, 32'h1000_0000);
    check("first_addr", bus.imem_addr, 32'h4);
    check("wrap_pc0", bus_w.id_pc, 32'hFFFF_FFF8);
    check("wrap_insn0", bus_w.id_insn, 32'h4FFF_FFFE);
    step();
    check("stream_pc4", bus.id_pc, 32'h4);
    check("stream_insn4", bus.id_insn, 32'h1000_0001);
    check("wrap_pc1", bus_w.id_pc, 32'hFFFF_FFFC);
    step();
    check("stream_pc8", bus.id_pc, 32'h8);
    check("wrap_pc2", bus_w.id_pc, 32'h0);
    check("wrap_insn2", bus_w.id_insn, 32'h1000_0000);
    step();
    check("stream_pc12", bus.id_pc, 32'hC);
    check("stream_valid", {31'b0, bus.id_valid}, 32'h1);

    // backpressure after a fresh reset
    rst = 1'b1;
    bus.id_ready = 1'b0;
    step();
    check("bp_rst_valid", {31'b0, bus.id_valid}, 32'h0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      check("bp_hold_valid", {31'b0, bus.id_valid}, 32'h1);
      check("bp_hold_pc", bus.id_pc, 32'h0);
    end
    check("bp_stall_addr", bus.imem_addr, 32'h8);
    bus.id_ready = 1'b1;
    step();
    check("bp_seq_pc4", bus.id_pc, 32'h4);
    step();
    check("bp_seq_pc8", bus.id_pc, 32'h8);
    check("bp_seq_insn8", bus.id_insn, 32'h1000_0002);

    // redirect while full (entries 8, 12 held)
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0042;
    step();
    bus.redirect_valid = 1'b0;
    check("rdf_addr", bus.imem_addr, 32'h40);
    check("rdf_valid", {31'b0, bus.id_valid}, 32'h0);
    step();
    check("rdf_tgt_valid", {31'b0, bus.id_valid}, 32'h1);
    check("rdf_tgt_pc", bus.id_pc, 32'h40);
    check("rdf_tgt_insn", bus.id_insn, 32'h1000_0010);
    step();
    check("rdf_hold_pc", bus.id_pc, 32'h40);

    // redirect with simultaneous pop
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    check("rdp_handshake", {31'b0, bus.id_valid & bus.id_ready}, 32'h1);
    step();
    bus.redirect_valid = 1'b0;
    check("rdp_valid", {31'b0, bus.id_valid}, 32'h0);
    check("rdp_addr", bus.imem_addr, 32'h100);
    step();
    check("rdp_tgt_pc", bus.id_pc, 32'h100);
    check("rdp_tgt_insn", bus.id_insn, 32'h1000_0040);
    step();
    check("run_pc104", bus.id_pc, 32'h104);
    step();
    check("run_pc108", bus.id_pc, 32'h108);
    step();
    check("run_pc10c", bus.id_pc, 32'h10C);
    step();
    check("run_pc110", bus.id_pc, 32'h110);

    // mid-run reset overrides a concurrent redirect
    rst = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    step();
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    check("mrst_addr", bus.imem_addr, 32'h0);
    check("mrst_valid", {31'b0, bus.id_valid}, 32'h0);
    step();
    check("mrst_pc0", bus.id_pc, 32'h0);
    check("mrst_valid1", {31'b0, bus.id_valid}, 32'h1);
    step();
    check("mrst_pc4", bus.id_pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage inside the cpu; sits directly between the asynchronous instruction ROM and the decode stage.
- Owns the program counter and drives imem_addr; captures imem_insn in the same cycle into a small prefetch FIFO.
- Presents {pc, insn} to decode over a valid/ready handshake and accepts branch/jump redirects, which flush all prefetched entries.

Parameters:
- address_size, 32, width of the PC and imem_addr.
- word_size, 32, instruction width.
- reset_pc, 32'h0000_0000, PC value after reset.
- fifo_depth, 2, number of prefetch entries (power of two, 2..8).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  address_size  fetch address, equal to the PC register.
- imem_insn  in  word_size  ROM data for imem_addr, valid in the same cycle.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_pc  in  address_size  redirect target.
- id_valid  out  1  FIFO head holds a valid entry.
- id_ready  in  1  decode accepts the head this cycle.
- id_pc  out  address_size  PC of the head entry.
- id_insn  out  word_size  instruction of the head entry.

Behaviour:
- Reset, checked at the clock edge while rst=1: pc<=reset_pc; FIFO emptied (count=0, pointers=0). Outputs during and after reset: imem_addr=reset_pc, id_valid=0; id_pc and id_insn are 0 when the FIFO is empty.
- imem_addr is driven combinationally from the pc register only; imem_insn is never registered outside the FIFO.
- pop = id_valid & id_ready.
- push = !redirect_valid & (count<fifo_depth | pop). A full FIFO accepts a push when a pop occurs in the same cycle.
- On push: the entry {pc, imem_insn} is written at the tail and pc<=pc+4. Addition is modulo 2^address_size, so 32'hFFFF_FFFC wraps to 0.
- With no push and no redirect, pc holds.
- Latency: an instruction fetched in cycle N appears at id_* in cycle N+1. Throughput is 1 instruction per cycle while id_ready=1.
- Redirect has priority over push and pop:
  - At the edge, the FIFO is flushed (count<=0) and pc<=redirect_pc with bits[1:0] forced to 00.
  - A pop in the same cycle still counts as a handshake for decode, but no entry survives the flush.
  - id_valid=0 in the cycle after the redirect; the target instruction is at id_* two cycles after the redirect.
- Back-to-back redirects: the last one wins and no entries are pushed in between.
- id_* outputs hold stable while id_valid=1 and id_ready=0.
- count never exceeds fifo_depth; the pointers wrap modulo fifo_depth.
- rst asserted mid-operation behaves identically to power-on reset at the next edge and overrides any redirect.

Decomposition:
- Package cpu_pkg:
  - INSN_BYTES=4
  - NOP_INSN=32'h0000_0013
  - fetch_entry_t packed struct {pc, insn}, parameterised by address_size/word_size through package localparams.
- Sub-module fetch_fifo:
  - Synchronous FIFO with flush input, width address_size+word_size, depth fifo_depth.
  - Interface: push, pop, flush, full, empty, head data.
  - if_stage contains the PC logic, the push/redirect arbitration and one fetch_fifo instance.

Test Plan:
- Reset release: rst=1 for 2 cycles, then 0, id_ready=1, ROM word i = 32'h1000_0000+i -> during reset imem_addr=0 and id_valid=0; on the first cycle after release id_valid=1, id_pc=0, id_insn=32'h1000_0000; then id_pc 4, 8, 12 on consecutive cycles.
- Backpressure: id_ready=0 for 6 cycles after reset -> FIFO fills with pc 0 and 4; imem_addr stalls at 8; id_pc=0 held stable. After id_ready=1, id_pc sequence is 0, 4, 8 with no gap or duplicate.
- Redirect while full: FIFO full, redirect_valid=1 with redirect_pc=32'h0000_0042 -> next cycle imem_addr=32'h40 and id_valid=0; following cycle id_pc=32'h40 with that word's insn. The stale pcs 0 and 4 never reappear.
- Redirect with simultaneous pop: id_valid=1, id_ready=1, redirect to 32'h100 -> one handshake is counted; next cycle id_valid=0; following cycle id_pc=32'h100.
- Wrap-around: reset_pc=32'hFFFF_FFF8, id_ready=1 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Mid-run reset: after 5 fetched instructions, assert rst for 1 cycle together with redirect_valid=1 -> imem_addr=reset_pc, id_valid=0, redirect ignored; fetch restarts from reset_pc.
